// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and constants for the memory access sequencer
package mcu_pkg;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mem_state_t;
   localparam int DATA_W = 16;
   localparam int MEM_TIMEOUT = 15;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 8-bit wait-state counter flagging when the count reaches TIMEOUT
module mem_wait_timer
   import mcu_pkg::*;
#(
   parameter int TIMEOUT = MEM_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);
   logic [7:0] cnt;
   always_ff @(posedge clk)
      if (reset || clear) cnt <= '0;
      else if (en) cnt <= cnt + 8'd1;
   assign expired = cnt == 8'(TIMEOUT);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one read or write against external memory with a bounded ready wait
module mem_access_ctrl
   import mcu_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int TIMEOUT = MEM_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] address,
   input  logic [WIDTH-1:0] bus,
   input  logic             rd,
   input  logic             wr,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             err
);
   mem_state_t state, state_n;
   logic expired, active;
   assign active = state == READ || state == WRITE;
   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == IDLE || state == DONE),
      .en      (active),
      .expired (expired)
   );
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:        state_n = (rd && !wr) ? READ : (wr && !rd) ? WRITE : IDLE;
         READ, WRITE: state_n = (mem_ready || expired) ? DONE : state;
         default:     state_n = IDLE;
      endcase
   end
   // Strobes and status decode only the state register, so no input reaches them combinationally.
   always_comb begin
      mem_rd = state == READ;
      mem_wr = state == WRITE;
      busy   = state != IDLE;
      done   = state == DONE;
   end
   always_ff @(posedge clk)
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         data_out  <= '0;
         err       <= 1'b0;
      end else begin
         if (state == IDLE && rd && wr) err <= 1'b1;
         else if (state == IDLE && (rd || wr)) begin
            mem_addr <= address;
            err      <= 1'b0;
            if (wr) mem_wdata <= bus;
         end
         if (state == READ && mem_ready) data_out <= mem_rdata;
         // A ready arriving on the timeout cycle still counts as success.
         if (active && expired && !mem_ready) err <= 1'b1;
      end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard-driven self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
   import mcu_pkg::*;
   localparam int W  = 16;
   localparam int TO = 15;
   logic clk = 1'b0;
   logic reset, rd, wr, mem_ready;
   logic [W-1:0] address, bus, mem_rdata, mem_addr, mem_wdata, data_out;
   logic mem_rd, mem_wr, busy, done, err;
   typedef struct {
      int           strobes;
      logic         err;
      logic [W-1:0] data;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
   } exp_t;
   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_data, exp_addr, exp_wdata;
   int strobes;
   bit got_done, bad_strobe;
   logic [W-1:0] o_data, o_addr, o_wdata;
   logic o_err;
   logic [1:0] o_tail;
   exp_t e;
   always #5 clk = ~clk;
   mem_access_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .bus       (bus),
      .rd        (rd),
      .wr        (wr),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // Reference model: predicts strobe length, err and register contents of one transaction.
   function automatic void expect_txn(input bit is_rd, input logic [W-1:0] a, d, input int wait_n);
      exp_t x;
      bit to;
      to = wait_n > TO;
      exp_addr = a;
      if (!is_rd) exp_wdata = d;
      if (is_rd && !to) exp_data = d;
      x.strobes = to ? TO + 1 : wait_n + 1;
      x.err = to;
      x.data = exp_data;
      x.addr = exp_addr;
      x.wdata = exp_wdata;
      sb.push_back(x);
   endfunction
   task automatic do_txn(input bit is_rd, input logic [W-1:0] a, d, input int wait_n, input bit inject);
      address = a;
      bus = d;
      rd = is_rd;
      wr = !is_rd;
      tick;
      rd = 1'b0;
      wr = 1'b0;
      strobes = 0;
      got_done = 0;
      bad_strobe = 0;
      o_addr = mem_addr;
      o_wdata = mem_wdata;
      for (int k = 1; k <= 300 && !got_done; k++) begin
         mem_ready = k == wait_n + 1;
         mem_rdata = d;
         wr = inject && k == 2;
         if (is_rd ? mem_rd : mem_wr) strobes++;
         if (is_rd ? mem_wr : mem_rd) bad_strobe = 1;
         if (k == 1 && err !== 1'b0) bad_strobe = 1;
         tick;
         got_done = done;
      end
      mem_ready = 1'b0;
      wr = 1'b0;
      o_data = data_out;
      o_err = err;
      tick;
      o_tail = {busy, done};
   endtask
   task automatic test_reset;
      reset = 1'b1;
      rd = 1'b0;
      wr = 1'b0;
      mem_ready = 1'b0;
      address = '0;
      bus = '0;
      mem_rdata = '0;
      tick;
      tick;
      reset = 1'b0;
      exp_data = '0;
      exp_addr = '0;
      exp_wdata = '0;
      n_cmp++;
      if ({mem_addr, mem_wdata, data_out, mem_rd, mem_wr, busy, done, err} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got addr=%h wdata=%h data=%h rd=%b wr=%b busy=%b done=%b err=%b want all 0",
                  mem_addr, mem_wdata, data_out, mem_rd, mem_wr, busy, done, err);
      end
   endtask
   task automatic test_zero_wait_read;
      expect_txn(1, 16'h1234, 16'hBEEF, 0);
      do_txn(1, 16'h1234, 16'hBEEF, 0, 0);
      e = sb.pop_front();
      n_cmp++;
      if (strobes !== e.strobes || !got_done) begin
         n_bad++;
         $display("FAIL zw_read_strobes: got %0d done=%b want %0d", strobes, got_done, e.strobes);
      end
      n_cmp++;
      if ({o_data, o_err} !== {e.data, e.err}) begin
         n_bad++;
         $display("FAIL zw_read_data: got %h err=%b want %h err=%b", o_data, o_err, e.data, e.err);
      end
      n_cmp++;
      if (o_addr !== e.addr || bad_strobe) begin
         n_bad++;
         $display("FAIL zw_read_addr: got %h bad_strobe=%b want %h", o_addr, bad_strobe, e.addr);
      end
      n_cmp++;
      if (o_tail !== 2'b00) begin
         n_bad++;
         $display("FAIL zw_read_tail: got busy,done=%b want 00", o_tail);
      end
   endtask
   task automatic test_write_wait;
      expect_txn(0, 16'h00FF, 16'hA5A5, 3);
      do_txn(0, 16'h00FF, 16'hA5A5, 3, 0);
      e = sb.pop_front();
      n_cmp++;
      if (strobes !== e.strobes || !got_done) begin
         n_bad++;
         $display("FAIL wr_wait_strobes: got %0d done=%b want %0d", strobes, got_done, e.strobes);
      end
      n_cmp++;
      if ({o_addr, o_wdata} !== {e.addr, e.wdata} || bad_strobe) begin
         n_bad++;
         $display("FAIL wr_wait_latch: got addr=%h wdata=%h bad=%b want %h %h", o_addr, o_wdata, bad_strobe, e.addr, e.wdata);
      end
      n_cmp++;
      if ({o_data, o_err, o_tail} !== {e.data, e.err, 2'b00}) begin
         n_bad++;
         $display("FAIL wr_wait_data: got %h err=%b tail=%b want %h err=%b", o_data, o_err, o_tail, e.data, e.err);
      end
   endtask
   task automatic test_read_timeout;
      expect_txn(1, 16'h2222, 16'h1111, 1000);
      expect_txn(1, 16'h3333, 16'h3C3C, 2);
      do_txn(1, 16'h2222, 16'h1111, 1000, 0);
      e = sb.pop_front();
      n_cmp++;
      if (strobes !== e.strobes || !got_done) begin
         n_bad++;
         $display("FAIL timeout_strobes: got %0d done=%b want %0d", strobes, got_done, e.strobes);
      end
      n_cmp++;
      if ({o_data, o_err, o_tail} !== {e.data, e.err, 2'b00}) begin
         n_bad++;
         $display("FAIL timeout_err: got %h err=%b tail=%b want %h err=%b", o_data, o_err, o_tail, e.data, e.err);
      end
      do_txn(1, 16'h3333, 16'h3C3C, 2, 0);
      e = sb.pop_front();
      n_cmp++;
      if ({strobes, o_data, o_err, bad_strobe} !== {e.strobes, e.data, e.err, 1'b0} || !got_done) begin
         n_bad++;
         $display("FAIL timeout_clear: got n=%0d %h err=%b bad=%b want n=%0d %h err=%b", strobes, o_data, o_err, bad_strobe, e.strobes, e.data, e.err);
      end
   endtask
   task automatic test_illegal;
      address = 16'hDEAD;
      bus = 16'hDEAD;
      rd = 1'b1;
      wr = 1'b1;
      tick;
      rd = 1'b0;
      wr = 1'b0;
      n_cmp++;
      if ({err, busy, mem_rd, mem_wr, done} !== 5'b10000) begin
         n_bad++;
         $display("FAIL illegal_flags: got err,busy,rd,wr,done=%b want 10000", {err, busy, mem_rd, mem_wr, done});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata} !== {exp_addr, exp_wdata}) begin
         n_bad++;
         $display("FAIL illegal_latch: got %h %h want %h %h", mem_addr, mem_wdata, exp_addr, exp_wdata);
      end
      tick;
      n_cmp++;
      if ({err, busy, done} !== 3'b100) begin
         n_bad++;
         $display("FAIL illegal_hold: got err,busy,done=%b want 100", {err, busy, done});
      end
   endtask
   task automatic test_busy_drop_tie;
      expect_txn(1, 16'h0A0A, 16'h5A5A, TO);
      do_txn(1, 16'h0A0A, 16'h5A5A, TO, 1);
      e = sb.pop_front();
      n_cmp++;
      if (strobes !== e.strobes || !got_done || bad_strobe) begin
         n_bad++;
         $display("FAIL tie_strobes: got %0d done=%b bad=%b want %0d", strobes, got_done, bad_strobe, e.strobes);
      end
      n_cmp++;
      if ({o_data, o_err, o_wdata, o_tail} !== {e.data, e.err, e.wdata, 2'b00}) begin
         n_bad++;
         $display("FAIL tie_data: got %h err=%b wdata=%h tail=%b want %h err=%b wdata=%h", o_data, o_err, o_wdata, o_tail, e.data, e.err, e.wdata);
      end
   endtask
   task automatic test_reset_mid_read;
      address = 16'h4444;
      rd = 1'b1;
      tick;
      rd = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      exp_data = '0;
      exp_addr = '0;
      exp_wdata = '0;
      n_cmp++;
      if ({mem_addr, mem_wdata, data_out, mem_rd, mem_wr, busy, done, err} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got addr=%h data=%h rd=%b busy=%b done=%b err=%b want all 0",
                  mem_addr, data_out, mem_rd, busy, done, err);
      end
      tick;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL midreset_nodone: got busy,done=%b want 00", {busy, done});
      end
      expect_txn(1, 16'h4545, 16'h7777, 1);
      do_txn(1, 16'h4545, 16'h7777, 1, 0);
      e = sb.pop_front();
      n_cmp++;
      if ({strobes, o_data, o_addr, o_err} !== {e.strobes, e.data, e.addr, e.err} || !got_done) begin
         n_bad++;
         $display("FAIL midreset_reread: got n=%0d %h %h err=%b want n=%0d %h %h err=%b", strobes, o_data, o_addr, o_err, e.strobes, e.data, e.addr, e.err);
      end
   endtask
   task automatic test_back_to_back;
      logic [W-1:0] da[3] = '{16'h1001, 16'h2002, 16'h3003};
      int wa[3] = '{0, 5, 2};
      bit ra[3] = '{1, 0, 1};
      for (int i = 0; i < 3; i++) expect_txn(ra[i], 16'h0100 + 16'(i), da[i], wa[i]);
      for (int i = 0; i < 3; i++) begin
         do_txn(ra[i], 16'h0100 + 16'(i), da[i], wa[i], 0);
         e = sb.pop_front();
         n_cmp++;
         if ({strobes, o_data, o_addr, o_wdata, o_err, o_tail} !== {e.strobes, e.data, e.addr, e.wdata, e.err, 2'b00} || !got_done || bad_strobe) begin
            n_bad++;
            $display("FAIL b2b_%0d: got n=%0d %h %h %h err=%b want n=%0d %h %h %h err=%b", i, strobes, o_data, o_addr, o_wdata, o_err, e.strobes, e.data, e.addr, e.wdata, e.err);
         end
      end
   endtask
   initial begin
      test_reset;
      test_zero_wait_read;
      test_write_wait;
      test_read_timeout;
      test_illegal;
      test_busy_drop_tie;
      test_reset_mid_read;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
